link_on_out_gen: RTL and testbench



---
 rtl/link_on_out_gen.sv | 147 ++++++++++++++
 tb/tb_link_on_out_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_on_out_gen.sv
// link_on_out_gen: LINK_ON line generator for the transmitter board.
// LINK_ON rises only after link_req & link_ready have held for a settle time.
// Minimum high and low widths are enforced so the receiver's 1-clock low-glitch
// stretcher never swallows an edge.
// Optional feature macro: LINK_ON_DROP_CNT_EN adds drop_cnt_clr / drop_cnt,
// a saturating 8-bit count of ON -> HOLD_OFF transitions.
// Handshake note: there is no valid/ready pair here. Inputs are level signals
// sampled every clk edge, and all outputs are registered levels.
module link_on_out_gen #(
    parameter int SETTLE_CYC  = 250,
    parameter int MIN_ON_CYC  = 4,
    parameter int MIN_OFF_CYC = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_req,
    input  logic       link_ready,
    input  logic       force_off,
`ifdef LINK_ON_DROP_CNT_EN
    input  logic       drop_cnt_clr,
    output logic [7:0] drop_cnt,
`endif
    output logic       link_on,
    output logic [1:0] link_state,
    output logic       busy
);

    // A settle of 0 behaves as 1. The off time is at least 3 cycles, because
    // the receiver filter masks single-cycle lows.
    localparam int SETTLE_EFF  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int MIN_OFF_EFF = (MIN_OFF_CYC < 3) ? 3 : MIN_OFF_CYC;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_T  = CNT_W'(SETTLE_EFF);
    localparam logic [CNT_W-1:0] MIN_ON_T  = CNT_W'(MIN_ON_CYC);
    localparam logic [CNT_W-1:0] MIN_OFF_T = CNT_W'(MIN_OFF_EFF);

    typedef enum logic [1:0] {
        ST_OFF      = 2'b00,
        ST_SETTLE   = 2'b01,
        ST_ON       = 2'b10,
        ST_HOLD_OFF = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             drop_pend, drop_pend_nxt;
    logic             go;
    logic             drop_req;

    // The state register is itself the debug view of the FSM.
    assign link_state = state;

    // Next state, counter and pending-drop latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        drop_pend_nxt = drop_pend;
        go            = link_req & link_ready & ~force_off;
        drop_req      = ~link_req | ~link_ready;
        case (state)
            ST_OFF: begin
                if (go) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = ONE;
                end
            end
            ST_SETTLE: begin
                // link_on was never high here, so an abort needs no hold-off.
                if (!go) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_T) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = ONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            ST_ON: begin
                // force_off ignores the minimum on time. A normal drop that
                // arrives early is latched and taken once the count is reached.
                if (force_off || ((drop_req || drop_pend) && (cnt >= MIN_ON_T))) begin
                    state_nxt     = ST_HOLD_OFF;
                    cnt_nxt       = ONE;
                    drop_pend_nxt = 1'b0;
                end else begin
                    if (drop_req) begin
                        drop_pend_nxt = 1'b1;
                    end
                    if (cnt < MIN_ON_T) begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            ST_HOLD_OFF: begin
                // Inputs are ignored. Re-acquisition always restarts from OFF.
                if (cnt == MIN_OFF_T) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs. link_on and busy follow the new state on
    // the same edge, and reset clears them without any hold-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            cnt       <= '0;
            drop_pend <= 1'b0;
            link_on   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            drop_pend <= drop_pend_nxt;
            link_on   <= (state_nxt == ST_ON);
            busy      <= (state_nxt == ST_SETTLE) || (state_nxt == ST_HOLD_OFF);
        end
    end

`ifdef LINK_ON_DROP_CNT_EN
    logic on_to_hold;
    assign on_to_hold = (state == ST_ON) && (state_nxt == ST_HOLD_OFF);

    // Saturating drop counter. A clear wins over a simultaneous drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop_cnt_clr) begin
            drop_cnt <= 8'd0;
        end else if (on_to_hold && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_link_on_out_gen.sv
// tb_link_on_out_gen: two instances share one set of inputs.
// Instance a uses the default timing (settle 250, on 4, off 4).
// Instance b uses settle 6, on 4, off 1; its off time is clamped to 3.
// A phase/timestamp reference model predicts every output on every edge.
`timescale 1ns/1ps
module tb_link_on_out_gen;

    localparam int A_SETTLE = 250, A_MINON = 4, A_MINOFF = 4;
    localparam int B_SETTLE = 6,   B_MINON = 4, B_MINOFF = 1;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic link_req = 1'b0, link_ready = 1'b0, force_off = 1'b0, drop_cnt_clr = 1'b0;
    logic a_on, b_on, a_busy, b_busy;
    logic [1:0] a_st, b_st;
    logic [7:0] dut_vec;
`ifdef LINK_ON_DROP_CNT_EN
    logic [7:0] a_dc, b_dc;
`endif

    always #20 clk = ~clk;

    assign dut_vec = {b_on, b_st, b_busy, a_on, a_st, a_busy};

    link_on_out_gen #(.SETTLE_CYC(A_SETTLE), .MIN_ON_CYC(A_MINON), .MIN_OFF_CYC(A_MINOFF), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .link_req(link_req), .link_ready(link_ready), .force_off(force_off),
`ifdef LINK_ON_DROP_CNT_EN
        .drop_cnt_clr(drop_cnt_clr), .drop_cnt(a_dc),
`endif
        .link_on(a_on), .link_state(a_st), .busy(a_busy)
    );

    link_on_out_gen #(.SETTLE_CYC(B_SETTLE), .MIN_ON_CYC(B_MINON), .MIN_OFF_CYC(B_MINOFF), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .link_req(link_req), .link_ready(link_ready), .force_off(force_off),
`ifdef LINK_ON_DROP_CNT_EN
        .drop_cnt_clr(drop_cnt_clr), .drop_cnt(b_dc),
`endif
        .link_on(b_on), .link_state(b_st), .busy(b_busy)
    );

    // ---------------- reference model ----------------
    // Phase 0 OFF, 1 SETTLE, 2 ON, 3 HOLD_OFF. mark holds the edge number at
    // which the current phase was entered; ages are edge-number differences.
    int checks = 0, errors = 0;
    int t = 0;
    int ms[2], mark[2], mdc[2], p_set[2], p_on[2], p_off[2];
    bit pend[2];
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    function automatic int at_least(int v, int lo);
        return (v < lo) ? lo : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mark[i] = 0; pend[i] = 1'b0; mdc[i] = 0;
        end
    endtask

    task automatic model_edge(int i, logic req, logic rdy, logic frc, logic clr);
        logic gov;
        logic dropped;
        int age;
        gov = req & rdy & ~frc;
        age = t - mark[i];
        dropped = 1'b0;
        case (ms[i])
            0: if (gov) begin ms[i] = 1; mark[i] = t; end
            1: begin
                if (!gov) ms[i] = 0;
                else if (age == p_set[i]) begin ms[i] = 2; mark[i] = t; pend[i] = 1'b0; end
            end
            2: begin
                if (frc || ((pend[i] || !(req && rdy)) && age >= p_on[i])) begin
                    ms[i] = 3; mark[i] = t; pend[i] = 1'b0; dropped = 1'b1;
                end else if (!(req && rdy)) begin
                    pend[i] = 1'b1;
                end
            end
            default: if (age == p_off[i]) ms[i] = 0;
        endcase
        if (clr) mdc[i] = 0;
        else if (dropped && mdc[i] < 255) mdc[i] = mdc[i] + 1;
    endtask

    function automatic logic [3:0] model_vec(int i);
        logic [1:0] s;
        s = 2'(ms[i]);
        return {s == 2'b10, s, (s == 2'b01) || (s == 2'b11)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(logic req, logic rdy, logic frc);
        link_req = req; link_ready = rdy; force_off = frc;
    endtask

    // One clock edge: advance the model with the sampled inputs and queue the
    // expected outputs. Returns 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        t = t + 1;
        if (!rst_n) model_reset();
        else for (int i = 0; i < 2; i++) model_edge(i, link_req, link_ready, force_off, drop_cnt_clr);
        exp_q.push_back({model_vec(1), model_vec(0)});
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        #5;
        checks++; if (dut_vec !== {model_vec(1), model_vec(0)} || dut_vec !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 8'h00); end
`ifdef LINK_ON_DROP_CNT_EN
        checks++; if ({b_dc, a_dc} !== 16'h0000) begin errors++; $display("FAIL reset_drop_cnt got=%h exp=0000", {b_dc, a_dc}); end
`endif
        step(); step();
        exp_q.delete();
        #5 rst_n = 1'b1;
    endtask

    task automatic go_idle();
        drive(1'b0, 1'b0, 1'b0);
        repeat (12) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL idle got=%b exp=%b t=%0d", dut_vec, exp, t); end
        end
    endtask

    task automatic test_settle();
        int n;
        drive(1'b1, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            step(); n++;
            exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL settle got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (n == 1) begin
                checks++; if (a_st !== 2'b01 || a_busy !== 1'b1 || a_on !== 1'b0) begin errors++; $display("FAIL settle_enter st=%b busy=%b on=%b exp st=01 busy=1 on=0", a_st, a_busy, a_on); end
            end
            if (a_on) break;
        end
        checks++; if (n != A_SETTLE + 1 || a_st !== 2'b10 || a_busy !== 1'b0) begin errors++; $display("FAIL settle_rise edges=%0d exp=%0d st=%b busy=%b", n, A_SETTLE + 1, a_st, a_busy); end
    endtask

    task automatic test_settle_abort();
        int n;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        repeat (100) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL abort got=%b exp=%b t=%0d", dut_vec, exp, t); end
        end
        drive(1'b1, 1'b0, 1'b0);
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL abort got=%b exp=%b t=%0d", dut_vec, exp, t); end
        checks++; if (a_st !== 2'b00 || a_on !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL abort_off st=%b on=%b exp st=00 on=0", a_st, a_on); end
        drive(1'b1, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            step(); n++;
            exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL abort got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (a_on) break;
        end
        checks++; if (n != A_SETTLE + 1) begin errors++; $display("FAIL abort_resettle edges=%0d exp=%0d", n, A_SETTLE + 1); end
    endtask

    task automatic test_min_on();
        int high_n, hold_n;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 400; k++) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL min_on got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (a_on) break;
        end
        high_n = a_on ? 1 : 0;
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL min_on got=%b exp=%b t=%0d", dut_vec, exp, t); end
        if (a_on) high_n++;
        // One-cycle drop request; it must be latched, not re-sampled.
        drive(1'b0, 1'b1, 1'b0);
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL min_on got=%b exp=%b t=%0d", dut_vec, exp, t); end
        if (a_on) high_n++;
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (!a_on) break;
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL min_on got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (a_on) high_n++;
        end
        checks++; if (high_n != A_MINON) begin errors++; $display("FAIL min_on_width high=%0d exp=%0d", high_n, A_MINON); end
        hold_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_st !== 2'b11) break;
            hold_n++;
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL min_on got=%b exp=%b t=%0d", dut_vec, exp, t); end
        end
        checks++; if (hold_n != A_MINOFF || a_st !== 2'b00 || a_on !== 1'b0) begin errors++; $display("FAIL min_off_width hold=%0d exp=%0d st=%b exp_st=00", hold_n, A_MINOFF, a_st); end
    endtask

    task automatic test_force_off();
        int a_hold, b_hold;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 400; k++) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL force got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (a_on) break;
        end
        drive(1'b1, 1'b1, 1'b1);
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL force got=%b exp=%b t=%0d", dut_vec, exp, t); end
        checks++; if (a_on !== 1'b0 || a_st !== 2'b11 || b_on !== 1'b0 || b_st !== 2'b11) begin errors++; $display("FAIL force_drop a=%b/%b b=%b/%b exp 0/11 0/11", a_on, a_st, b_on, b_st); end
        // go held during hold-off must be ignored.
        drive(1'b1, 1'b1, 1'b0);
        a_hold = 1; b_hold = 1;
        for (int k = 0; k < 12; k++) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL force got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (a_st === 2'b11) a_hold++;
            if (b_st === 2'b11) b_hold++;
            if (k == 2) begin
                checks++; if (b_st !== 2'b00 || b_on !== 1'b0) begin errors++; $display("FAIL force_b_after_hold st=%b on=%b exp st=00 on=0", b_st, b_on); end
            end
        end
        checks++; if (b_hold != 3 || a_hold != A_MINOFF) begin errors++; $display("FAIL force_hold_width a=%0d exp=%0d b=%0d exp=3", a_hold, A_MINOFF, b_hold); end
    endtask

    task automatic test_reset_async();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            go_idle();
            drive(1'b1, 1'b1, 1'b0);
            // pass 0: reset mid-SETTLE; pass 1: reset while a is ON.
            for (int k = 0; k < 400; k++) begin
                step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL rst_async got=%b exp=%b t=%0d", dut_vec, exp, t); end
                if ((pass == 0 && k == 49) || (pass == 1 && a_on)) break;
            end
            #10 rst_n = 1'b0;
            model_reset();
            #1;
            checks++; if (a_on !== 1'b0 || a_st !== 2'b00 || dut_vec !== {model_vec(1), model_vec(0)}) begin errors++; $display("FAIL rst_async_now pass=%0d got=%b exp=00000000", pass, dut_vec); end
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL rst_async got=%b exp=%b t=%0d", dut_vec, exp, t); end
            #5 rst_n = 1'b1;
            n = 0;
            for (int k = 0; k < 400; k++) begin
                step(); n++;
                exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL rst_async got=%b exp=%b t=%0d", dut_vec, exp, t); end
                if (a_on) break;
            end
            checks++; if (n != A_SETTLE + 1) begin errors++; $display("FAIL rst_async_resettle pass=%0d edges=%0d exp=%0d", pass, n, A_SETTLE + 1); end
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int seg = 0; seg < 12; seg++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive(1'b1, 1'b1, 1'b0);
                repeat (300) begin
                    step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL random got=%b exp=%b t=%0d", dut_vec, exp, t); end
                end
            end else begin
                repeat (200) begin
                    drive($urandom_range(0, 15) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0);
`ifdef LINK_ON_DROP_CNT_EN
                    drop_cnt_clr = ($urandom_range(0, 63) == 0);
`endif
                    step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL random got=%b exp=%b t=%0d", dut_vec, exp, t); end
`ifdef LINK_ON_DROP_CNT_EN
                    checks++; if (a_dc !== 8'(mdc[0]) || b_dc !== 8'(mdc[1])) begin errors++; $display("FAIL random_drop_cnt got=%0d/%0d exp=%0d/%0d", a_dc, b_dc, mdc[0], mdc[1]); end
`endif
                end
            end
        end
        drop_cnt_clr = 1'b0;
    endtask

`ifdef LINK_ON_DROP_CNT_EN
    task automatic test_drop_cnt();
        go_idle();
        drop_cnt_clr = 1'b1;
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
        drop_cnt_clr = 1'b0;
        checks++; if (b_dc !== 8'd0) begin errors++; $display("FAIL drop_cnt_clear got=%0d exp=0", b_dc); end
        for (int it = 0; it < 300; it++) begin
            drive(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 20; k++) begin
                step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
                if (b_on) break;
            end
            drive(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 20; k++) begin
                step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
                if (b_st === 2'b00) break;
            end
        end
        checks++; if (b_dc !== 8'd255 || b_dc !== 8'(mdc[1]) || a_dc !== 8'(mdc[0])) begin errors++; $display("FAIL drop_cnt_sat got=%0d exp=255 a=%0d exp_a=%0d", b_dc, a_dc, mdc[0]); end
        // Clear on the same edge as a drop: the clear wins.
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (b_on) break;
        end
        repeat (B_MINON) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
        end
        drive(1'b0, 1'b1, 1'b0);
        drop_cnt_clr = 1'b1;
        step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
        drop_cnt_clr = 1'b0;
        checks++; if (b_st !== 2'b11 || b_dc !== 8'd0) begin errors++; $display("FAIL drop_cnt_clr_wins st=%b cnt=%0d exp st=11 cnt=0", b_st, b_dc); end
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(); exp = exp_q.pop_front(); checks++; if (dut_vec !== exp) begin errors++; $display("FAIL drop_cnt got=%b exp=%b t=%0d", dut_vec, exp, t); end
            if (b_on) break;
        end
        go_idle();
        checks++; if (b_dc !== 8'd1) begin errors++; $display("FAIL drop_cnt_after_clr got=%0d exp=1", b_dc); end
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        p_set[0] = at_least(A_SETTLE, 1); p_on[0] = A_MINON; p_off[0] = at_least(A_MINOFF, 3);
        p_set[1] = at_least(B_SETTLE, 1); p_on[1] = B_MINON; p_off[1] = at_least(B_MINOFF, 3);
        test_reset();
        test_settle();
        test_settle_abort();
        test_min_on();
        test_force_off();
        test_reset_async();
        test_random();
`ifdef LINK_ON_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

endmodule
